data_mem_uart_dumper: RTL
=========================

// Module: data_mem_uart_dumper
// PURPOSE
// - Read-side initiator on the CPU data-memory bus (address / out_data / WE): after the program finishes, it reads a block of data memory and streams it to a host.
// - On start_i it reads word_count_i words from base_addr_i and sends each word as 4 UART bytes (8N1, LSB-first).
// - Sits beside the CPU at the data-memory port; the top-level mux gives it the bus while busy_o=1. Never writes.
// PARAMETERS
// - CLKS_PER_BIT  434  CLK cycles per UART bit (50 MHz / 115200)
// - READ_LATENCY  1    cycles from address driven to data_mem_out_data_i valid (1..4)
// - ADDR_STEP     4    address increment per word
// - CNT_W         16   width of word_count_i
// PORTS
// - CLK                  in   1      system clock, all logic rising-edge
// - RST                  in   1      synchronous reset, active-high
// - start_i              in   1      1-cycle pulse, sampled only in IDLE
// - base_addr_i          in   32     first word address, latched on accepted start
// - word_count_i         in   CNT_W  number of words, latched on accepted start
// - data_mem_address_o   out  32     read address to data memory
// - data_mem_out_data_i  in   32     read data from data memory
// - data_mem_WE_o        out  1      constant 0
// - busy_o               out  1      1 from the cycle after start is accepted until done
// - done_o               out  1      1-cycle pulse at end of transfer
// - uart_tx_o            out  1      serial output, idle high
// BEHAVIOUR
// - Reset: state=IDLE, uart_tx_o=1, busy_o=0, done_o=0, data_mem_address_o=0, data_mem_WE_o=0, all counters and checksum=0.
// - FSM: IDLE -> REQ -> WAIT -> LOAD -> START -> DATA -> STOP -> {START | REQ | [CHK] | DONE} -> IDLE.
// - IDLE: on start_i, latch base_addr_i and word_count_i. If the count is 0, go to DONE and send nothing; otherwise go to REQ.
// - REQ: drive data_mem_address_o = current address. Hold it stable through WAIT and LOAD.
// - WAIT: READ_LATENCY-1 cycles; skipped when READ_LATENCY=1.
// - LOAD: capture data_mem_out_data_i into a 32-bit word register. Byte index=0.
// - Byte order: little-endian. Bytes go out as word[7:0], [15:8], [23:16], [31:24].
// - UART frame: START bit low, 8 data bits LSB-first, STOP bit high. Each bit lasts exactly CLKS_PER_BIT cycles, so one frame is 10*CLKS_PER_BIT cycles.
// - Consecutive frames are back-to-back, with no extra idle bit between bytes of a word.
// - After STOP:
//   - Byte index <3: go to START for the next byte.
//   - Byte index =3 and words remain: address += ADDR_STEP (mod 2^32, wraps 0xFFFFFFFC -> 0x0 silently), then REQ.
//   - Otherwise: go to CHK (if enabled) or DONE.
// - uart_tx_o stays high between words, during REQ/WAIT/LOAD.
// - DONE: done_o=1 for one cycle, busy_o drops in the same cycle, next state IDLE. A new start is accepted the cycle after DONE.
// - start_i while busy is ignored. It is not queued, and the latched base and count stay unchanged.
// - Input changes on base_addr_i / word_count_i mid-transfer have no effect.
// - Address wraps mod 2^32. The word counter is CNT_W bits, so the maximum transfer is 2^CNT_W-1 words.
// - RST mid-frame: uart_tx_o=1 on the next cycle. No partial frame continues, and done_o is not pulsed.
// - data_mem_WE_o is 0 in every state, including during reset.
// CONFIGURATION
// - DUMP_CHECKSUM_EN defined:
//   - An 8-bit checksum register XOR-accumulates every data byte sent; it is cleared on accepted start.
//   - After the last data byte, state CHK sends one extra 8N1 frame holding the checksum, then goes to DONE.
//   - With word_count=0 nothing is sent and no checksum frame either.
// - DUMP_CHECKSUM_EN undefined: no CHK state and no checksum register; STOP of the last byte goes straight to DONE.
// TESTING (bench: CLKS_PER_BIT=4, READ_LATENCY=1, memory model returns addr^32'hA5A5_0000)
// - Single word: reset, start base=0x10 count=1.
//   - Frames 0x10,0x00,0xA5,0xA5 in that order, 160 tx cycles.
//   - done_o pulses once; address 0x10 is held through LOAD.
// - Three words at base 0x100:
//   - Addresses 0x100, 0x104, 0x108; 12 frames in little-endian order.
//   - uart_tx_o stays high in each inter-word REQ/LOAD gap.
//   - busy_o is high throughout.
// - Zero count: start count=0.
//   - uart_tx_o stays 1, done_o pulses 2 cycles after start, and no address toggles.
// - Ignored start: pulse start base=0x200 during the second frame of a count=2 transfer from 0x40.
//   - Only 0x40 and 0x44 are read; exactly one done_o.
// - Wrap and reset:
//   - base=0xFFFFFFFC count=2: second address is 0x00000000.
//   - Assert RST mid-data-bit: uart_tx_o=1 the next cycle, busy_o=0, no done_o.
// - With DUMP_CHECKSUM_EN, base=0x10 count=1: a fifth frame 0x10^0x00^0xA5^0xA5 = 0x10 follows, then done_o.

Source files
------------

// File: rtl/data_mem_uart_dumper.sv
// rtl/data_mem_uart_dumper.sv - reads a block of data memory and streams it out as 8N1 UART bytes
// Optional feature macro: DUMP_CHECKSUM_EN (appends one XOR-checksum frame after the data bytes)
module data_mem_uart_dumper #(
  parameter int CLKS_PER_BIT = 434,
  parameter int READ_LATENCY = 1,
  parameter int ADDR_STEP    = 4,
  parameter int CNT_W        = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start_i,
  input  logic [31:0]      base_addr_i,
  input  logic [CNT_W-1:0] word_count_i,
  output logic [31:0]      data_mem_address_o,
  input  logic [31:0]      data_mem_out_data_i,
  output logic             data_mem_WE_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             uart_tx_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_REQ, S_WAIT, S_LOAD, S_START, S_DATA, S_STOP,
`ifdef DUMP_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE
  } state_t;

  state_t           r_state, w_next;
  logic [31:0]      r_addr;
  logic [31:0]      r_word;
  logic [CNT_W-1:0] r_words_left;
  logic [15:0]      r_baud;
  logic [3:0]       r_bit;
  logic [1:0]       r_byte;
  logic [2:0]       r_wait;
  logic             r_tx, r_busy, r_done;
  logic             w_tx, w_bit_end, w_wait_end, w_last_word;
`ifdef DUMP_CHECKSUM_EN
  logic [7:0]       r_csum;
  logic [9:0]       w_chk_frame;
  assign w_chk_frame = {1'b1, r_csum, 1'b0};
`endif

  assign w_bit_end   = (r_baud == 16'(CLKS_PER_BIT - 1));
  assign w_wait_end  = (r_wait == 3'(READ_LATENCY - 2));
  assign w_last_word = (r_words_left == CNT_W'(1));

  assign data_mem_address_o = r_addr;
  assign data_mem_WE_o      = 1'b0;
  assign busy_o             = r_busy;
  assign done_o             = r_done;
  assign uart_tx_o          = r_tx;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode and the serial line level for the current bit
  always_comb begin
    w_next = r_state;
    w_tx   = 1'b1;
    case (r_state)
      S_IDLE:  if (start_i) w_next = (word_count_i == '0) ? S_DONE : S_REQ;
      S_REQ:   w_next = (READ_LATENCY > 1) ? S_WAIT : S_LOAD;
      S_WAIT:  if (w_wait_end) w_next = S_LOAD;
      S_LOAD:  w_next = S_START;
      S_START: begin
        w_tx = 1'b0;
        if (w_bit_end) w_next = S_DATA;
      end
      S_DATA: begin
        w_tx = r_word[{2'b00, r_bit[2:0]}];
        if (w_bit_end && r_bit == 4'd7) w_next = S_STOP;
      end
      S_STOP: begin
        if (w_bit_end) begin
          if (r_byte != 2'd3)    w_next = S_START;
          else if (!w_last_word) w_next = S_REQ;
          else
`ifdef DUMP_CHECKSUM_EN
            w_next = S_CHK;
`else
            w_next = S_DONE;
`endif
        end
      end
`ifdef DUMP_CHECKSUM_EN
      S_CHK: begin
        w_tx = w_chk_frame[r_bit];
        if (w_bit_end && r_bit == 4'd9) w_next = S_DONE;
      end
`endif
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: address/word/counters plus registered outputs (all lag state by one cycle)
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_addr       <= '0;
      r_word       <= '0;
      r_words_left <= '0;
      r_baud       <= '0;
      r_bit        <= '0;
      r_byte       <= '0;
      r_wait       <= '0;
      r_tx         <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      r_csum       <= '0;
`endif
    end else begin
      r_tx   <= w_tx;
      r_busy <= (r_state != S_IDLE) && (r_state != S_DONE);
      r_done <= (r_state == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_words_left <= word_count_i;
            // A zero-length request leaves the bus address untouched
            if (word_count_i != '0) r_addr <= base_addr_i;
`ifdef DUMP_CHECKSUM_EN
            r_csum <= '0;
`endif
          end
        end
        S_REQ:  r_wait <= '0;
        S_WAIT: r_wait <= r_wait + 3'd1;
        S_LOAD: begin
          r_word <= data_mem_out_data_i;
          r_byte <= '0;
          r_baud <= '0;
          r_bit  <= '0;
        end
        S_START: r_baud <= w_bit_end ? 16'd0 : r_baud + 16'd1;
        S_DATA: begin
          r_baud <= w_bit_end ? 16'd0 : r_baud + 16'd1;
          if (w_bit_end) r_bit <= (r_bit == 4'd7) ? 4'd0 : r_bit + 4'd1;
        end
        S_STOP: begin
          r_baud <= w_bit_end ? 16'd0 : r_baud + 16'd1;
          if (w_bit_end) begin
`ifdef DUMP_CHECKSUM_EN
            r_csum <= r_csum ^ r_word[7:0];
`endif
            if (r_byte != 2'd3) begin
              // Next byte of the same word moves into the low lane
              r_byte <= r_byte + 2'd1;
              r_word <= {8'h00, r_word[31:8]};
            end else if (!w_last_word) begin
              r_words_left <= r_words_left - CNT_W'(1);
              r_addr       <= r_addr + 32'(ADDR_STEP);
            end
          end
        end
`ifdef DUMP_CHECKSUM_EN
        S_CHK: begin
          r_baud <= w_bit_end ? 16'd0 : r_baud + 16'd1;
          if (w_bit_end) r_bit <= r_bit + 4'd1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
